// File: rtl/noc_pkg.sv
// Shared definitions for the router input port: default flit width,
// VC index sizing and the output-side FSM state encoding.
package noc_pkg;

  localparam int DEF_WORD_WIDTH = 128;

  function automatic int vc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND
  } state_t;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel circular buffer. Full/empty come straight from the
// occupancy count; writes to a full buffer and reads from an empty one are ignored.
module vc_fifo
  import noc_pkg::*;
#(
  parameter int BUFFER_DEPTH = 8,
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  localparam int AW = $clog2(BUFFER_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [WORD_WIDTH-1:0] i_din,
  output logic [WORD_WIDTH-1:0] o_dout,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [WORD_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign o_full  = (r_count == CW'(BUFFER_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vc_input_port.sv
// Router input port: per-VC FIFOs with credit return, round-robin VC selection,
// switch-allocator request and bounded-burst drain under out_ready backpressure.
module vc_input_port
  import noc_pkg::*;
#(
  parameter int NUM_VC       = 4,
  parameter int BUFFER_DEPTH = 8,
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int MAX_BURST    = 4,
  localparam int VCW = vc_idx_w(NUM_VC),
  localparam int CW  = $clog2(BUFFER_DEPTH) + 1,
  localparam int BW  = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [VCW-1:0]        in_vc,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic [NUM_VC-1:0]     credit_out,
  output logic                  out_req,
  output logic [VCW-1:0]        out_req_vc,
  input  logic                  out_grant,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [VCW-1:0]        out_vc,
  output logic [NUM_VC-1:0]     vc_empty,
  output logic                  overflow_err
);

  logic [WORD_WIDTH-1:0] w_dout  [NUM_VC];
  logic [CW-1:0]         w_count [NUM_VC];
  logic [NUM_VC-1:0]     w_full, w_empty, w_wr_en, w_rd_en, w_sel_oh;
  logic                  w_pop, w_wr_sel, w_last, w_any;
  logic [VCW-1:0]        w_pick;

  state_t                r_state;
  logic [VCW-1:0]        r_sel, r_rr, r_out_vc;
  logic [BW-1:0]         r_burst;
  logic                  r_out_req, r_out_valid, r_ovf;
  logic [WORD_WIDTH-1:0] r_out_data;
  logic [NUM_VC-1:0]     r_credit;

  genvar g;
  generate
    for (g = 0; g < NUM_VC; g++) begin : g_vc
      vc_fifo #(
        .BUFFER_DEPTH(BUFFER_DEPTH),
        .WORD_WIDTH  (WORD_WIDTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_wr_en[g]),
        .i_rd_en (w_rd_en[g]),
        .i_din   (in_data),
        .o_dout  (w_dout[g]),
        .o_count (w_count[g]),
        .o_full  (w_full[g]),
        .o_empty (w_empty[g])
      );
    end
  endgenerate

  always_comb begin
    w_wr_en = '0;
    if (in_valid) w_wr_en[in_vc] = 1'b1;
  end

  assign w_sel_oh = {{(NUM_VC-1){1'b0}}, 1'b1} << r_sel;
  assign w_pop    = (r_state == SEND) && out_ready && !w_empty[r_sel];
  assign w_rd_en  = w_pop ? w_sel_oh : '0;
  assign w_wr_sel = in_valid && (in_vc == r_sel) && !w_full[r_sel];
  // A pop of the last word ends the burst unless a refill lands in the same cycle.
  assign w_last   = ((w_count[r_sel] == CW'(1)) && !w_wr_sel) ||
                    (r_burst == BW'(MAX_BURST - 1));

  // Descending scan so the smallest offset from the RR pointer wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (!w_empty[r_rr + VCW'(i)]) begin
        w_any  = 1'b1;
        w_pick = r_rr + VCW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_rr        <= '0;
      r_burst     <= '0;
      r_out_req   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_vc    <= '0;
      r_credit    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      r_credit    <= w_pop ? w_sel_oh : '0;
      if (w_pop) begin
        r_out_data <= w_dout[r_sel];
        r_out_vc   <= r_sel;
      end
      if (in_valid && w_full[in_vc]) r_ovf <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel     <= w_pick;
            r_out_req <= 1'b1;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (out_grant) begin
            r_burst   <= '0;
            r_out_req <= 1'b0;
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (w_empty[r_sel]) begin
            r_rr    <= r_sel + VCW'(1);
            r_state <= IDLE;
          end else if (w_pop) begin
            r_burst <= r_burst + BW'(1);
            if (w_last) begin
              r_rr    <= r_sel + VCW'(1);
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign credit_out   = r_credit;
  assign out_req      = r_out_req;
  assign out_req_vc   = r_sel;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_vc       = r_out_vc;
  assign vc_empty     = w_empty;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_vc_input_port.sv
// Scoreboard bench for vc_input_port: per-VC model queues filled on write,
// checked against every out_valid word, plus RR order, credit and overflow checks.
module tb_vc_input_port;

  localparam int NV = 4;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_grant, out_ready;
  logic [1:0]    in_vc;
  logic [DW-1:0] in_data;
  logic [NV-1:0] credit_out, vc_empty;
  logic          out_req, out_valid, overflow_err;
  logic [1:0]    out_req_vc, out_vc;
  logic [DW-1:0] out_data;

  int n_cmp = 0, n_err = 0, n_out = 0, n_grant = 0, cyc = 0;
  int mark = 0, first_cyc = 0, last_cyc = 0;
  logic prev_ready = 1'b0;
  logic [DW-1:0] q_model [NV][$];
  int exp_vc_q[$];

  vc_input_port #(
    .NUM_VC(NV), .BUFFER_DEPTH(8), .WORD_WIDTH(DW), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data),
    .credit_out(credit_out), .out_req(out_req), .out_req_vc(out_req_vc),
    .out_grant(out_grant), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_vc(out_vc), .vc_empty(vc_empty),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int vc, input logic [DW-1:0] d, input bit drop);
    in_valid = 1'b1;
    in_vc    = vc[1:0];
    in_data  = d;
    if (!drop) q_model[vc].push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int target, input int budget, input string tag);
    int k = 0;
    while (n_out < target && k < budget) begin
      step();
      k++;
    end
    repeat (4) step();
    chk(tag, n_out, target);
  endtask

  // Output monitor: every word must match the model, carry a matching credit,
  // and follow a cycle where out_ready was high.
  always @(negedge clk) begin
    if (out_valid) begin
      chk("pop_needs_ready", prev_ready, 1'b1);
      chk("credit", credit_out, 4'b0001 << out_vc);
      if (q_model[out_vc].size() == 0) chk("spurious_word", q_model[out_vc].size(), 1);
      else chk("data", out_data, q_model[out_vc].pop_front());
      if (exp_vc_q.size() > 0) chk("rr_order", out_vc, exp_vc_q.pop_front());
      if (n_out == mark) first_cyc = cyc;
      last_cyc = cyc;
      n_out++;
    end else if (credit_out != '0) begin
      chk("stray_credit", credit_out, 0);
    end
    if (out_req && out_grant) n_grant++;
    prev_ready = out_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int wr_left;
    int base;
    rst = 1'b1; in_valid = 1'b0; in_vc = '0; in_data = '0;
    out_grant = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_out_req", out_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_credit", credit_out, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_empty", vc_empty, 4'hF);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_vc", out_vc, 0);
    chk("rst_req_vc", out_req_vc, 0);
    rst = 1'b0;
    step();

    // Three words on VC2, grant two cycles late
    out_ready = 1'b1; n_grant = 0; mark = n_out;
    wr(2, 'hA, 0); wr(2, 'hB, 0); wr(2, 'hC, 0);
    chk("t1_req", out_req, 1);
    chk("t1_req_vc", out_req_vc, 2);
    chk("t1_not_empty", vc_empty, 4'b1011);
    step(); step();
    out_grant = 1'b1;
    wait_drain(mark + 3, 50, "t1_count");
    chk("t1_back_to_back", last_cyc - first_cyc, 2);
    chk("t1_empty", vc_empty, 4'hF);
    chk("t1_idle", out_req, 0);
    chk("t1_grants", n_grant, 1);
    out_grant = 1'b0;

    // Six words on VC0: split into a 4-word and a 2-word burst
    n_grant = 0; mark = n_out;
    for (int i = 0; i < 6; i++) wr(0, 'h200 + i, 0);
    out_grant = 1'b1;
    wait_drain(mark + 6, 80, "t2_count");
    chk("t2_grants", n_grant, 2);
    out_grant = 1'b0;

    // VC0 and VC1 with five words each: bursts must alternate
    n_grant = 0; mark = n_out;
    exp_vc_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 5; i++) wr(0, 'h300 + i, 0);
    for (int i = 0; i < 5; i++) wr(1, 'h310 + i, 0);
    out_grant = 1'b1;
    wait_drain(mark + 10, 120, "t3_count");
    chk("t3_grants", n_grant, 4);
    chk("t3_order_left", exp_vc_q.size(), 0);
    out_grant = 1'b0;

    // Overflow on VC3: ninth word dropped, flag sticky
    n_grant = 0; mark = n_out;
    for (int i = 0; i < 8; i++) wr(3, 'h400 + i, 0);
    chk("t4_ovf_before", overflow_err, 0);
    chk("t4_not_empty", vc_empty, 4'b0111);
    wr(3, 'h4FF, 1);
    chk("t4_ovf_set", overflow_err, 1);
    out_grant = 1'b1;
    wait_drain(mark + 8, 120, "t4_count");
    chk("t4_ovf_sticky", overflow_err, 1);
    chk("t4_empty", vc_empty, 4'hF);
    chk("t4_grants", n_grant, 2);
    out_grant = 1'b0;

    // Pointer wrap with alternating out_ready
    mark = n_out; base = n_out;
    for (int i = 0; i < 8; i++) wr(1, 'h500 + i, 0);
    out_grant = 1'b1; out_ready = 1'b1;
    k = 0; wr_left = 5;
    while (n_out < base + 13 && k < 400) begin
      out_ready = ~out_ready;
      if (n_out >= base + 5 && wr_left > 0) begin
        in_valid = 1'b1; in_vc = 2'd1; in_data = 'h510 + wr_left;
        q_model[1].push_back('h510 + wr_left);
        wr_left--;
      end else begin
        in_valid = 1'b0;
      end
      step();
      k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("t5_count", n_out, base + 13);
    chk("t5_model_empty", q_model[1].size(), 0);
    chk("t5_empty", vc_empty, 4'hF);
    out_grant = 1'b0;

    // Reset in the middle of a burst
    mark = n_out;
    for (int i = 0; i < 3; i++) wr(2, 'h600 + i, 0);
    out_grant = 1'b1;
    k = 0;
    while (n_out <= mark && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t6_first_word", n_out, mark + 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_credit", credit_out, 0);
    chk("t6_out_req", out_req, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_vc", out_vc, 0);
    chk("t6_req_vc", out_req_vc, 0);
    chk("t6_ovf_cleared", overflow_err, 0);
    chk("t6_empty", vc_empty, 4'hF);
    q_model[2].delete();
    rst = 1'b0; out_grant = 1'b0;
    mark = n_out;
    repeat (6) step();
    chk("t6_no_more_words", n_out, mark);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
